msrv_lu_seq: RTL and testbench
==============================

# msrv_lu_seq

Parametrised sequential load unit for the msrv core family. It accepts one load per handshake and issues one or two aligned bus reads, splitting misaligned accesses that span two bus words. It then extracts, aligns and sign/zero-extends the result, and returns it as a registered one-cycle response. It replaces the purely combinational 32-bit load unit between the memory-bus interface and the writeback stage.

## Interface
Parameters:
- XLEN, 32: data/bus width in bits; legal values are 32 or 64.
- ALLOW_MISALIGNED, 1:
  - 1: accesses that are not naturally aligned are split as needed.
  - 0: such accesses return an error with no bus access.

Ports:
- clk_in  in  1  core clock; all state changes on the rising edge.
- rst_n_in  in  1  reset, asynchronous and active-low.
- req_valid_in  in  1  load request valid.
- req_ready_out  out  1  unit idle and able to accept a request.
- load_size_in  in  2  access size: 00 byte, 01 half, 10 word, 11 double. With XLEN=32, 11 is treated as 10.
- load_unsigned_in  in  1  1 = zero-extend, 0 = sign-extend.
- addr_in  in  32  byte address of the load.
- bus_req_out  out  1  bus read request; held until bus_ack_in.
- bus_addr_out  out  32  read address, aligned to XLEN/8 bytes.
- bus_ack_in  in  1  read data/response valid this cycle.
- bus_data_in  in  XLEN  read data, sampled with bus_ack_in.
- ahb_resp_in  in  1  bus response, sampled with bus_ack_in: 0 OKAY, 1 ERROR.
- lu_valid_out  out  1  one-cycle response strobe.
- lu_output  out  XLEN  extended load result; holds its value between responses.
- lu_err_out  out  1  error flag, valid with lu_valid_out.

## Operation
- FSM states: IDLE, FIRST, SECOND, RESP.
- req_ready_out is 1 only in IDLE.
- A request is accepted on an edge with req_valid_in & req_ready_out. On acceptance the unit latches size, unsigned, addr_in, and the word offset `off = addr[log2(XLEN/8)-1:0]`.
- Access length is `nbytes = 1 << size`.
- span = (off + nbytes > XLEN/8).
- misaligned = (off mod nbytes != 0).
- Transitions from IDLE:
  - If ALLOW_MISALIGNED=0 and misaligned: go to RESP with err=1 and no bus request.
  - Otherwise: go to FIRST.
- FIRST:
  - bus_req_out=1 and bus_addr_out = addr with the low offset bits cleared.
  - Wait for bus_ack_in. On ack with ahb_resp_in=1: go to RESP with err=1.
  - On ack with OKAY: store bus_data_in as beat0. Go to SECOND if span, else RESP.
- SECOND:
  - bus_addr_out = aligned addr + XLEN/8, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
  - On ack: an error goes to RESP with err=1; OKAY stores beat1 and goes to RESP.
- RESP:
  - lu_valid_out=1 for exactly one cycle, then return to IDLE.
- Result computation:
  - raw = ({beat1, beat0} >> (8*off)), low nbytes bytes.
  - Extend to XLEN: sign from the top byte of raw unless unsigned.
  - Word size with XLEN=64 extends to 64 bits.
- On error, lu_output is loaded with 0 and lu_err_out=1.
- bus_ack_in outside FIRST/SECOND is ignored.
- req_valid_in while busy is ignored and not queued.

## Timing
- Reset values:
  - state IDLE; req_ready_out=1.
  - bus_req_out=0, bus_addr_out=0.
  - lu_valid_out=0, lu_output=0, lu_err_out=0.
  - beat0 = beat1 = 0.
- Reset mid-operation:
  - bus_req_out drops asynchronously and the in-flight load is discarded.
  - No lu_valid_out is produced for it.
- Request accepted at edge N:
  - bus_req_out is high from cycle N+1.
  - bus_addr_out is stable while bus_req_out=1.
- Ack sampled at edge M leads to the next bus request (if SECOND) or lu_valid_out in cycle M+1.
- Minimum latency from acceptance to lu_valid_out (zero-wait bus):
  - 2 cycles non-spanning.
  - 3 cycles spanning.
  - 1 cycle for a rejected misaligned access.
- The next request can be accepted in the cycle after RESP, since IDLE is re-entered at that edge.
- lu_output, lu_err_out and lu_valid_out are all registered; there is no combinational path from bus inputs to outputs.

## Structure
- Package msrv_lu_pkg holds:
  - size encodings (LU_BYTE, LU_HALF, LU_WORD, LU_DOUBLE);
  - the FSM state enum;
  - response encodings (RESP_OKAY, RESP_ERROR).
- Sub-module msrv_lu_align (combinational) takes beat0, beat1, off, size and unsigned, and produces the extended XLEN result.
- The top level holds the FSM, request latches and bus interface.

## Test plan
- XLEN=32, byte signed, addr 0x1003, ack immediate with data 0x8011_2233 -> lu_output 0xFFFF_FF80, err 0, lu_valid_out 2 cycles after acceptance.
- Half unsigned, addr 0x2002, data 0xBEEF_0000 -> lu_output 0x0000_BEEF. Only one bus request, at 0x2000.
- Word, addr 0x3003:
  - beat0 at 0x3000 = 0x4433_2211, beat1 at 0x3004 = 0x8877_6655 -> 0x7766_5544.
  - With 2 wait cycles per beat, bus_addr_out stays stable throughout and the response comes at cycle 7.
- Spanning word at 0xFFFF_FFFE -> second bus_addr_out 0x0000_0000. ERROR on the second beat -> lu_err_out=1, lu_output=0, no third request.
- ALLOW_MISALIGNED=0, half at 0x1001 -> bus_req_out never asserted, error response 1 cycle after acceptance. An aligned half that follows completes normally.
- XLEN=64, word signed at 0x...4 with data 0x8000_0000_0000_0000 -> 0xFFFF_FFFF_8000_0000.
- Reset asserted during SECOND -> bus_req_out 0 immediately, no lu_valid_out. After release, req_ready_out=1 and a new byte load completes normally.

Source files
------------

// File: rtl/msrv_lu_pkg.sv
// Shared encodings for the msrv sequential load unit: access sizes, FSM states, bus responses.
package msrv_lu_pkg;

    typedef enum logic [1:0] {
        LU_BYTE   = 2'b00,
        LU_HALF   = 2'b01,
        LU_WORD   = 2'b10,
        LU_DOUBLE = 2'b11
    } lu_size_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FIRST  = 2'b01,
        SECOND = 2'b10,
        RESP   = 2'b11
    } lu_state_e;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

endpackage

// File: rtl/msrv_lu_align.sv
// Extracts nbytes starting at byte offset off from {beat1, beat0} and sign/zero-extends to XLEN.
// Purely combinational, no state and no backpressure.
module msrv_lu_align
    import msrv_lu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0]              beat0_i,
    input  logic [XLEN-1:0]              beat1_i,
    input  logic [$clog2(XLEN/8)-1:0]    off_i,
    input  logic [1:0]                   size_i,
    input  logic                         unsigned_i,
    output logic [XLEN-1:0]              result_o
);

    logic [6:0]      nbits;
    logic [XLEN-1:0] shifted_lo;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] top_bit;
    logic            sign;

    always_comb begin
        nbits      = 7'd8 << size_i;
        shifted_lo = XLEN'({beat1_i, beat0_i} >> {off_i, 3'b000});
        // A full-width access shifts the 1 out entirely, so the subtraction yields all ones.
        keep       = (XLEN'(1) << nbits) - XLEN'(1);
        top_bit    = keep ^ (keep >> 1);
        sign       = |(shifted_lo & top_bit);
        result_o   = (shifted_lo & keep) | ((sign && !unsigned_i) ? ~keep : '0);
    end

endmodule

// File: rtl/msrv_lu_seq.sv
// Sequential load unit: one load per handshake, one or two aligned bus reads, registered result.
// Latency 2 cycles (3 when spanning, 1 on rejection); busy requests are ignored, bus stalls hold the FSM.
module msrv_lu_seq
    import msrv_lu_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic            clk_in,
    input  logic            rst_n_in,
    input  logic            req_valid_in,
    output logic            req_ready_out,
    input  logic [1:0]      load_size_in,
    input  logic            load_unsigned_in,
    input  logic [31:0]     addr_in,
    output logic            bus_req_out,
    output logic [31:0]     bus_addr_out,
    input  logic            bus_ack_in,
    input  logic [XLEN-1:0] bus_data_in,
    input  logic            ahb_resp_in,
    output logic            lu_valid_out,
    output logic [XLEN-1:0] lu_output,
    output logic            lu_err_out
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("msrv_lu_seq: XLEN must be 32 or 64");
    end

    lu_state_e       state_q, state_d;
    logic [1:0]      size_q, size_d;
    logic            uns_q, uns_d;
    logic [OFFW-1:0] off_q, off_d;
    logic            span_q, span_d;
    logic [31:0]     bus_addr_q, bus_addr_d;
    logic [XLEN-1:0] beat0_q, beat0_d;
    logic [XLEN-1:0] beat1_q, beat1_d;
    logic [XLEN-1:0] out_q, out_d;
    logic            err_q, err_d;

    logic [1:0]      req_size;
    logic [3:0]      req_nbytes;
    logic [OFFW-1:0] req_off;
    logic            req_span;
    logic            req_misal;
    logic [XLEN-1:0] align_res;

    // A 32-bit bus cannot carry a double; it degrades to a word access.
    always_comb begin
        req_size = load_size_in;
        if (XLEN == 32 && load_size_in == LU_DOUBLE) begin
            req_size = LU_WORD;
        end
        req_nbytes = 4'd1 << req_size;
        req_off    = addr_in[OFFW-1:0];
        req_span   = (5'(req_off) + 5'(req_nbytes)) > 5'(BYTES);
        req_misal  = (req_off & (OFFW'(req_nbytes) - OFFW'(1))) != '0;
    end

    // Fed with the next-state beats so the result is ready on the edge that enters RESP.
    msrv_lu_align #(
        .XLEN (XLEN)
    ) u_align (
        .beat0_i    (beat0_d),
        .beat1_i    (beat1_d),
        .off_i      (off_q),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .result_o   (align_res)
    );

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        uns_d      = uns_q;
        off_d      = off_q;
        span_d     = span_q;
        bus_addr_d = bus_addr_q;
        beat0_d    = beat0_q;
        beat1_d    = beat1_q;
        out_d      = out_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (req_valid_in) begin
                    size_d     = req_size;
                    uns_d      = load_unsigned_in;
                    off_d      = req_off;
                    span_d     = req_span;
                    bus_addr_d = {addr_in[31:OFFW], {OFFW{1'b0}}};
                    if (!ALLOW_MISALIGNED && req_misal) begin
                        state_d = RESP;
                        out_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = FIRST;
                    end
                end
            end
            FIRST: begin
                if (bus_ack_in) begin
                    if (ahb_resp_in == RESP_ERROR) begin
                        state_d = RESP;
                        out_d   = '0;
                        err_d   = 1'b1;
                    end else begin
                        beat0_d = bus_data_in;
                        if (span_q) begin
                            state_d    = SECOND;
                            bus_addr_d = bus_addr_q + 32'(BYTES);
                        end else begin
                            state_d = RESP;
                            out_d   = align_res;
                            err_d   = 1'b0;
                        end
                    end
                end
            end
            SECOND: begin
                if (bus_ack_in) begin
                    state_d = RESP;
                    if (ahb_resp_in == RESP_ERROR) begin
                        out_d = '0;
                        err_d = 1'b1;
                    end else begin
                        beat1_d = bus_data_in;
                        out_d   = align_res;
                        err_d   = 1'b0;
                    end
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q    <= IDLE;
            size_q     <= 2'b00;
            uns_q      <= 1'b0;
            off_q      <= '0;
            span_q     <= 1'b0;
            bus_addr_q <= 32'h0;
            beat0_q    <= '0;
            beat1_q    <= '0;
            out_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            off_q      <= off_d;
            span_q     <= span_d;
            bus_addr_q <= bus_addr_d;
            beat0_q    <= beat0_d;
            beat1_q    <= beat1_d;
            out_q      <= out_d;
            err_q      <= err_d;
        end
    end

    assign req_ready_out = (state_q == IDLE);
    assign bus_req_out   = (state_q == FIRST) || (state_q == SECOND);
    assign bus_addr_out  = bus_addr_q;
    assign lu_valid_out  = (state_q == RESP);
    assign lu_output     = out_q;
    assign lu_err_out    = err_q;

endmodule

// File: tb/tb_msrv_lu_seq.sv
// Directed bench for msrv_lu_seq: 32-bit misaligned-capable, 32-bit strict and 64-bit instances.
module tb_msrv_lu_seq;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic        ack;
    logic        resp;
    logic [63:0] data;
    logic [2:0]  vld;

    logic [2:0]  rdy;
    logic [2:0]  breq;
    logic [2:0]  lv;
    logic [2:0]  le;
    logic [31:0] baddr_a, baddr_n, baddr_w;
    logic [31:0] lo_a, lo_n;
    logic [63:0] lo_w;

    logic [1:0]  sel;
    logic        rdy_s, breq_s, lv_s, le_s;
    logic [31:0] baddr_s;
    logic [63:0] lo_s;

    int n_checks = 0;
    int n_errors = 0;

    msrv_lu_seq #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) u_dut_a (
        .clk_in(clk), .rst_n_in(rst_n),
        .req_valid_in(vld[0]), .req_ready_out(rdy[0]),
        .load_size_in(size), .load_unsigned_in(uns), .addr_in(addr),
        .bus_req_out(breq[0]), .bus_addr_out(baddr_a),
        .bus_ack_in(ack), .bus_data_in(data[31:0]), .ahb_resp_in(resp),
        .lu_valid_out(lv[0]), .lu_output(lo_a), .lu_err_out(le[0])
    );

    msrv_lu_seq #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) u_dut_n (
        .clk_in(clk), .rst_n_in(rst_n),
        .req_valid_in(vld[1]), .req_ready_out(rdy[1]),
        .load_size_in(size), .load_unsigned_in(uns), .addr_in(addr),
        .bus_req_out(breq[1]), .bus_addr_out(baddr_n),
        .bus_ack_in(ack), .bus_data_in(data[31:0]), .ahb_resp_in(resp),
        .lu_valid_out(lv[1]), .lu_output(lo_n), .lu_err_out(le[1])
    );

    msrv_lu_seq #(.XLEN(64), .ALLOW_MISALIGNED(1'b1)) u_dut_w (
        .clk_in(clk), .rst_n_in(rst_n),
        .req_valid_in(vld[2]), .req_ready_out(rdy[2]),
        .load_size_in(size), .load_unsigned_in(uns), .addr_in(addr),
        .bus_req_out(breq[2]), .bus_addr_out(baddr_w),
        .bus_ack_in(ack), .bus_data_in(data), .ahb_resp_in(resp),
        .lu_valid_out(lv[2]), .lu_output(lo_w), .lu_err_out(le[2])
    );

    always_comb begin
        rdy_s  = rdy[sel];
        breq_s = breq[sel];
        lv_s   = lv[sel];
        le_s   = le[sel];
        case (sel)
            2'd0:    begin baddr_s = baddr_a; lo_s = {32'd0, lo_a}; end
            2'd1:    begin baddr_s = baddr_n; lo_s = {32'd0, lo_n}; end
            default: begin baddr_s = baddr_w; lo_s = lo_w;          end
        endcase
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; issues one load and plays the bus side beat by beat.
    task automatic do_load(input string tag, input logic [1:0] which,
                           input logic [1:0] sz, input logic u, input logic [31:0] a,
                           input int nbeats, input int waits,
                           input logic [31:0] a0, input logic [63:0] d0, input logic r0,
                           input logic [31:0] a1, input logic [63:0] d1, input logic r1,
                           input logic [63:0] exp_out, input logic exp_err);
        sel = which;
        #1;
        check_eq({tag, "/rdy"}, 64'(rdy_s), 64'd1);
        size = sz; uns = u; addr = a; vld[which] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = '0;
        for (int b = 0; b < nbeats; b++) begin
            for (int w = 0; w <= waits; w++) begin
                check_eq({tag, "/breq"}, 64'(breq_s), 64'd1);
                check_eq({tag, "/baddr"}, 64'(baddr_s), 64'((b == 0) ? a0 : a1));
                check_eq({tag, "/early_vld"}, 64'(lv_s), 64'd0);
                if (w == waits) begin
                    ack  = 1'b1;
                    data = (b == 0) ? d0 : d1;
                    resp = (b == 0) ? r0 : r1;
                end
                @(posedge clk);
                @(negedge clk);
                ack = 1'b0; resp = 1'b0;
            end
        end
        check_eq({tag, "/vld"}, 64'(lv_s), 64'd1);
        check_eq({tag, "/out"}, lo_s, exp_out);
        check_eq({tag, "/err"}, 64'(le_s), 64'(exp_err));
        check_eq({tag, "/breq_resp"}, 64'(breq_s), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "/vld_drop"}, 64'(lv_s), 64'd0);
        check_eq({tag, "/rdy_after"}, 64'(rdy_s), 64'd1);
        check_eq({tag, "/breq_after"}, 64'(breq_s), 64'd0);
        check_eq({tag, "/out_hold"}, lo_s, exp_out);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        size = 2'b00; uns = 1'b0; addr = 32'h0; ack = 1'b0; resp = 1'b0;
        data = 64'h0; vld = 3'b000; sel = 2'd0;
        repeat (2) @(negedge clk);
        check_eq("reset/rdy", 64'(rdy), 64'h7);
        check_eq("reset/breq", 64'(breq), 64'h0);
        check_eq("reset/vld", 64'(lv), 64'h0);
        check_eq("reset/err", 64'(le), 64'h0);
        check_eq("reset/baddr", {baddr_a, baddr_w}, 64'h0);
        check_eq("reset/out32", {lo_a, lo_n}, 64'h0);
        check_eq("reset/out64", lo_w, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_load("byte_s", 2'd0, 2'b00, 1'b0, 32'h0000_1003, 1, 0,
                32'h0000_1000, 64'h8011_2233, 1'b0, 32'h0, 64'h0, 1'b0,
                64'h0000_0000_FFFF_FF80, 1'b0);
        do_load("half_u", 2'd0, 2'b01, 1'b1, 32'h0000_2002, 1, 0,
                32'h0000_2000, 64'hBEEF_0000, 1'b0, 32'h0, 64'h0, 1'b0,
                64'h0000_0000_0000_BEEF, 1'b0);
        do_load("word_span", 2'd0, 2'b10, 1'b0, 32'h0000_3003, 2, 2,
                32'h0000_3000, 64'h4433_2211, 1'b0, 32'h0000_3004, 64'h8877_6655, 1'b0,
                64'h0000_0000_7766_5544, 1'b0);
        do_load("wrap_err", 2'd0, 2'b10, 1'b0, 32'hFFFF_FFFE, 2, 0,
                32'hFFFF_FFFC, 64'h1111_2222, 1'b0, 32'h0000_0000, 64'h3333_4444, 1'b1,
                64'h0, 1'b1);
        do_load("dbl_as_word", 2'd0, 2'b11, 1'b0, 32'h0000_6000, 1, 0,
                32'h0000_6000, 64'h89AB_CDEF, 1'b0, 32'h0, 64'h0, 1'b0,
                64'h0000_0000_89AB_CDEF, 1'b0);
        do_load("strict_rej", 2'd1, 2'b01, 1'b0, 32'h0000_1001, 0, 0,
                32'h0, 64'h0, 1'b0, 32'h0, 64'h0, 1'b0,
                64'h0, 1'b1);
        do_load("strict_ok", 2'd1, 2'b01, 1'b0, 32'h0000_1002, 1, 0,
                32'h0000_1000, 64'hABCD_0000, 1'b0, 32'h0, 64'h0, 1'b0,
                64'h0000_0000_FFFF_ABCD, 1'b0);
        do_load("x64_word", 2'd2, 2'b10, 1'b0, 32'h0000_4004, 1, 0,
                32'h0000_4000, 64'h8000_0000_0000_0000, 1'b0, 32'h0, 64'h0, 1'b0,
                64'hFFFF_FFFF_8000_0000, 1'b0);
        do_load("x64_half_span", 2'd2, 2'b01, 1'b0, 32'h0000_5007, 2, 1,
                32'h0000_5000, 64'h1200_0000_0000_0000, 1'b0,
                32'h0000_5008, 64'h0000_0000_0000_009A, 1'b0,
                64'hFFFF_FFFF_FFFF_9A12, 1'b0);

        // Reset while the second beat is outstanding.
        sel = 2'd0;
        size = 2'b10; uns = 1'b0; addr = 32'h0000_3003; vld[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        vld = '0;
        ack = 1'b1; data = 64'h4433_2211; resp = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ack = 1'b0;
        check_eq("rst/in_second_breq", 64'(breq_s), 64'd1);
        check_eq("rst/in_second_baddr", 64'(baddr_s), 64'h0000_3004);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rst/breq_async", 64'(breq_s), 64'd0);
        check_eq("rst/vld_async", 64'(lv_s), 64'd0);
        @(negedge clk);
        check_eq("rst/vld_held", 64'(lv), 64'h0);
        check_eq("rst/out_cleared", lo_s, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst/no_resp", 64'(lv), 64'h0);
        do_load("after_rst", 2'd0, 2'b00, 1'b1, 32'h0000_7001, 1, 0,
                32'h0000_7000, 64'h0000_A500, 1'b0, 32'h0, 64'h0, 1'b0,
                64'h0000_0000_0000_00A5, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
